// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default addresses, FSM encoding,
// the IF/ID payload type and the fetch-address legality check.
package pc_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEFAULT = 4096;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ifid_entry_t;

  // Offset is taken unsigned, so an address below base wraps high and faults too.
  function automatic logic pc_is_faulty(input logic [31:0] pc,
                                        input logic [31:0] base,
                                        input logic [31:0] span);
    logic [31:0] offset;
    offset = pc - base;
    return (pc[1:0] != 2'b00) || (offset >= span);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface pc_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_fetch_unit_if_id.sv
// IF/ID pipeline register: loads a fetched entry, or clears to a bubble
// (clear has priority); PC_D is kept across bubbles.
module if_id_reg
  import pc_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  ifid_entry_t entry_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        adel_o
);

  ifid_entry_t entry_q, entry_d;
  logic        valid_q, valid_d;

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (clear_i) begin
      entry_d.instr = NOP_WORD;
      entry_d.adel  = 1'b0;
      valid_d       = 1'b0;
    end else if (load_i) begin
      entry_d = entry_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = entry_q.pc;
  assign instr_o = entry_q.instr;
  assign valid_o = valid_q;
  assign adel_o  = entry_q.adel;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns PC_F, runs the imem req/ack handshake, buffers a word that
// arrives while D is stalled, and remembers a redirect whose delay slot is late.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter int unsigned IM_WORDS = IM_WORDS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        next_pc,
  input  logic               npc_redirect,
  input  logic               stall_D,
  input  logic               flush_D,
  pc_fetch_unit_if.master    imem,
  output logic [31:0]        pc_F,
  output logic [31:0]        PC_D,
  output logic [31:0]        instr_D,
  output logic               valid_D,
  output logic               adel_D
);

  localparam logic [31:0] IM_SPAN = 32'(4 * IM_WORDS);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_q, redir_d;
  logic         pend_q, pend_d;
  logic [31:0]  hold_word_q, hold_word_d;
  logic         hold_adel_q, hold_adel_d;

  logic         pc_faulty;
  logic [31:0]  fetch_word;
  logic [31:0]  tgt;
  logic         pc_load;
  logic         id_load;
  logic         id_clear;
  ifid_entry_t  id_entry;

  assign pc_faulty  = pc_is_faulty(pc_q, IM_BASE, IM_SPAN);
  assign fetch_word = pc_faulty ? NOP_WORD : imem.rdata;
  assign tgt        = pend_q ? redir_q : next_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      redir_q     <= '0;
      pend_q      <= 1'b0;
      hold_word_q <= NOP_WORD;
      hold_adel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_q     <= redir_d;
      pend_q      <= pend_d;
      hold_word_q <= hold_word_d;
      hold_adel_q <= hold_adel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    pend_d      = pend_q;
    hold_word_d = hold_word_q;
    hold_adel_d = hold_adel_q;
    pc_load     = 1'b0;
    id_load     = 1'b0;
    id_entry    = '{pc: pc_q, instr: NOP_WORD, adel: 1'b0};

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        // A faulty PC completes locally without touching imem.
        if (pc_faulty || imem.ack) begin
          if (!stall_D) begin
            id_load        = 1'b1;
            id_entry.instr = fetch_word;
            id_entry.adel  = pc_faulty;
            pc_load        = 1'b1;
          end else begin
            hold_word_d = fetch_word;
            hold_adel_d = pc_faulty;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall_D) begin
          id_load        = 1'b1;
          id_entry.instr = hold_word_q;
          id_entry.adel  = hold_adel_q;
          pc_load        = 1'b1;
          state_d        = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // The branch leaves D before its delay slot is fetched: keep its target.
    if (pc_load) begin
      pc_d   = tgt;
      pend_d = 1'b0;
    end else if (npc_redirect && !stall_D) begin
      redir_d = next_pc;
      pend_d  = 1'b1;
    end
  end

  always_comb begin
    imem.req  = (state_q == ST_FETCH) && !pc_faulty;
    imem.addr = pc_q;
    id_clear  = flush_D || (!stall_D && !id_load);
  end

  assign pc_F = pc_q;

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (id_load),
    .clear_i (id_clear),
    .entry_i (id_entry),
    .pc_o    (PC_D),
    .instr_o (instr_D),
    .valid_o (valid_D),
    .adel_o  (adel_D)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural fetch model.
module tb_pc_fetch_unit;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int unsigned WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] next_pc = '0;
  logic        npc_redirect = 1'b0;
  logic        stall_D = 1'b0;
  logic        flush_D = 1'b0;
  logic [31:0] pc_F, PC_D, instr_D;
  logic        valid_D, adel_D;

  pc_fetch_unit_if imem_bus();

  pc_fetch_unit #(.RESET_PC(32'h0000_3000), .IM_BASE(BASE), .IM_WORDS(WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
    .npc_redirect (npc_redirect),
    .stall_D      (stall_D),
    .flush_D      (flush_D),
    .imem         (imem_bus),
    .pc_F         (pc_F),
    .PC_D         (PC_D),
    .instr_D      (instr_D),
    .valid_D      (valid_D),
    .adel_D       (adel_D)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_boot, m_hold, m_valid, m_adel, m_buf_adel;
  logic [31:0] m_pc, m_pcd, m_instr, m_buf_word;
  logic [31:0] m_pend[$];

  // Memory responder state
  int ack_delay = 0;
  int mem_wait  = 0;
  bit ack_force = 1'b1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic bit is_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < BASE) || (pc >= BASE + 4 * WORDS);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_hold = 1'b0;
    m_pc = 32'h3000; m_pcd = '0; m_instr = '0; m_valid = 1'b0; m_adel = 1'b0;
    m_pend.delete();
    mem_wait = 0;
  endtask

  // One clock cycle: compare, drive, compare combinational outputs, advance model.
  task automatic step(input bit st, input bit fl, input bit rd, input bit use_np, input logic [31:0] np);
    logic [31:0] npc, tgt, fw;
    bit f, ack, exp_req, fill, bub, fa;
    chk("pc_F", pc_F, m_pc);
    chk1("valid_D", valid_D, m_valid);
    chk("instr_D", instr_D, m_instr);
    chk1("adel_D", adel_D, m_adel);
    if (m_valid) chk("PC_D", PC_D, m_pcd);

    npc = use_np ? np : m_pc + 4;
    stall_D = st; flush_D = fl; npc_redirect = rd; next_pc = npc;
    ack = ack_force || (imem_bus.req && mem_wait >= ack_delay);
    if (imem_bus.req && !ack) mem_wait++;
    else mem_wait = 0;
    imem_bus.ack = ack;
    imem_bus.rdata = word_of(imem_bus.addr);
    f = is_fault(m_pc);
    exp_req = !m_boot && !m_hold && !f;
    #1;
    chk1("imem_req", imem_bus.req, exp_req);
    chk("imem_addr", imem_bus.addr, m_pc);
    @(posedge clk);

    tgt = (m_pend.size() != 0) ? m_pend[0] : npc;
    fill = 1'b0; bub = 1'b0; fw = '0; fa = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
      bub = !st;
    end else if (m_hold) begin
      if (!st) begin
        fill = 1'b1; fw = m_buf_word; fa = m_buf_adel; m_hold = 1'b0;
      end
    end else if (f || ack) begin
      fw = f ? 32'h0 : word_of(m_pc);
      fa = f;
      if (!st) fill = 1'b1;
      else begin
        m_buf_word = fw; m_buf_adel = fa; m_hold = 1'b1;
      end
    end else begin
      bub = !st;
    end
    if (fill) begin
      m_pcd = m_pc; m_instr = fw; m_adel = fa; m_valid = 1'b1;
      m_pc = tgt;
      m_pend.delete();
    end else if (rd && !st) begin
      m_pend.push_back(npc);
    end
    if (bub || fl) begin
      m_valid = 1'b0; m_instr = '0; m_adel = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom % 8)
      0, 1, 2, 3: return BASE + 4 * ($urandom % WORDS);
      4:          return BASE + 4 * WORDS - 4;
      5:          return BASE + 4 * WORDS;
      6:          return BASE - 4;
      default:    return BASE + 4 * ($urandom % 64) + 2;
    endcase
  endfunction

  initial begin
    bit st, fl, rd;
    imem_bus.ack = 1'b1;
    imem_bus.rdata = 32'hDEAD_BEEF;
    model_reset();

    // Asynchronous reset, before any clock edge, with ack already asserted
    #1 reset = 1'b0;
    #1;
    chk("rst_pc_F", pc_F, 32'h3000);
    chk("rst_PC_D", PC_D, 32'h0);
    chk1("rst_valid", valid_D, 1'b0);
    chk1("rst_req", imem_bus.req, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Boot cycle ignores the stray ack
    step(0, 0, 0, 0, 0);
    ack_force = 1'b0;
    chk1("lit_req_first", imem_bus.req, 1'b1);
    chk("lit_addr_3000", imem_bus.addr, 32'h3000);
    step(0, 0, 0, 0, 0);
    chk("lit_PC_D_3000", PC_D, 32'h3000);
    chk("lit_addr_3004", imem_bus.addr, 32'h3004);
    step(0, 0, 0, 0, 0);
    chk("lit_addr_3008", imem_bus.addr, 32'h3008);
    step(0, 0, 0, 0, 0);
    chk("lit_PC_D_3008", PC_D, 32'h3008);

    // Branch at 3008 redirects to 3100 while the delay slot ack is late
    ack_delay = 2;
    step(0, 0, 1, 1, 32'h3100);
    chk1("lit_redir_bubble1", valid_D, 1'b0);
    chk("lit_redir_pcF_held", pc_F, 32'h300C);
    step(0, 0, 0, 0, 0);
    chk1("lit_redir_bubble2", valid_D, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("lit_slot_PC_D", PC_D, 32'h300C);
    chk("lit_pcF_target", pc_F, 32'h3100);

    // Stall while the ack arrives: word parks in the hold buffer
    ack_delay = 1;
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk1("lit_hold_req", imem_bus.req, 1'b0);
    chk("lit_hold_pcF", pc_F, 32'h3100);
    step(1, 0, 0, 0, 0);
    chk1("lit_hold_req2", imem_bus.req, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("lit_hold_PC_D", PC_D, 32'h3100);
    chk("lit_hold_instr", instr_D, word_of(32'h3100));
    chk("lit_hold_next_pc", pc_F, 32'h3104);

    // Misaligned fetch faults locally
    ack_delay = 0;
    step(0, 0, 0, 1, 32'h3002);
    chk1("lit_fault_noreq", imem_bus.req, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("lit_fault_PC_D", PC_D, 32'h3002);
    chk("lit_fault_instr", instr_D, 32'h0);
    chk1("lit_fault_adel", adel_D, 1'b1);
    chk1("lit_fault_valid", valid_D, 1'b1);
    step(0, 0, 1, 1, 32'h3200);
    step(0, 1, 0, 0, 0);
    chk1("lit_flush_valid", valid_D, 1'b0);
    chk("lit_flush_pcF", pc_F, 32'h3204);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 16 == 0) ack_delay = int'($urandom % 4);
      st = ($urandom % 5) == 0;
      fl = ($urandom % 8) == 0;
      rd = m_valid && (m_pend.size() == 0) && (($urandom % 3) == 0);
      if (rd) step(st, fl, 1'b1, 1'b1, rand_target());
      else    step(st, fl, 1'b0, 1'b0, 32'h0);
    end

    // Reset asserted mid-request; a late ack must not leak through
    ack_delay = 3;
    for (int i = 0; i < 20 && !imem_bus.req; i++) step(0, 0, 0, 1, 32'h3400);
    chk1("pre_reset_req", imem_bus.req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("midrst_req", imem_bus.req, 1'b0);
    chk("midrst_pc_F", pc_F, 32'h3000);
    chk("midrst_PC_D", PC_D, 32'h0);
    chk1("midrst_valid", valid_D, 1'b0);
    chk1("midrst_adel", adel_D, 1'b0);
    model_reset();
    ack_force = 1'b1;
    imem_bus.ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    ack_force = 1'b0;
    ack_delay = 0;
    step(0, 0, 0, 0, 0);
    chk("post_rst_PC_D", PC_D, 32'h3000);
    chk1("post_rst_valid", valid_D, 1'b1);
    step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
